// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-requester memory bus arbiter.
// Holds word/address sizes, the arbiter state type and the default watchdog limit.
package mem_bus_arbiter_pkg;

  localparam int unsigned WORD_SIZE           = 19;
  localparam int unsigned ADDR_SIZE           = 20;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_e;

  // Round-robin pick: on a tie the requester not granted last wins.
  function automatic requester_e pick_winner(input logic       if_req,
                                             input logic       dm_req,
                                             input requester_e last_grant);
    if (if_req && dm_req) begin
      return (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
    end
    return dm_req ? REQ_DM : REQ_IF;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog: counts busy cycles without acknowledge and flags when LIMIT is reached.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  // Count holds 0 in the first busy cycle, so expiry lands on the LIMIT-th one.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single-outstanding memory port.
// Define ARB_TIMEOUT_EN to add the busy-cycle watchdog that aborts stuck accesses.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W         = WORD_SIZE,
  parameter int unsigned ADDR_W         = ADDR_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e state;
  requester_e last_grant;
  requester_e winner;

  assign winner = pick_winner(if_req, dm_req, last_grant);

`ifdef ARB_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;
  logic expired;

  assign wd_clear  = (state == IDLE);
  assign wd_enable = (state != IDLE) && !mem_ack;

  arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );
`else
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_IF;
      if_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      if_gnt   <= 1'b0;
      dm_gnt   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            last_grant <= winner;
            mem_req    <= 1'b1;
            if (winner == REQ_DM) begin
              state     <= BUSY_DM;
              dm_gnt    <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              state     <= BUSY_IF;
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_IF, BUSY_DM: begin
          // An acknowledge always wins over a coincident watchdog expiry.
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == BUSY_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_valid <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (expired) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            if (state == BUSY_IF) begin
              if_valid <= 1'b1;
            end else begin
              dm_valid <= 1'b1;
            end
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then randomized traffic against a reference model.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog path instead of the unbounded wait.
module tb_mem_bus_arbiter;

  localparam int unsigned DW = 19;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_valid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          timeout_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_valid    (if_valid),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_gnt      (dm_gnt),
    .dm_valid    (dm_valid),
    .dm_rdata    (dm_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .timeout_err (timeout_err)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  // Reference model: who was granted last, and what each requester should currently read back.
  logic          last_dm;
  logic [DW-1:0] exp_if_rdata, exp_dm_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset        = 1'b0;
    last_dm      = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: run did not finish within bound");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    logic          win_dm, exp_we, ir, dr;
    logic [AW-1:0] exp_addr, a_if, a_dm;
    logic [DW-1:0] rd, wd;
    logic [21:0]   held;
    int unsigned   bad;

    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    do_reset();
    chk("reset_ctrl", {if_gnt, if_valid, dm_gnt, dm_valid, mem_req, mem_we, timeout_err}, 0);
    chk("reset_bus", {mem_addr, mem_wdata}, 0);
    chk("reset_rdata", {if_rdata, dm_rdata}, 0);

    // Single fetch, memory acks two cycles after mem_req.
    if_req = 1'b1; if_addr = 20'h00010;
    tick();
    chk("fetch_gnt", {if_gnt, dm_gnt, mem_req, mem_we}, 4'b1010);
    chk("fetch_addr", mem_addr, 20'h00010);
    if_req = 1'b0; last_dm = 1'b0;
    tick();
    chk("fetch_wait", {if_gnt, if_valid, mem_req}, 3'b001);
    tick();
    mem_ack = 1'b1; mem_rdata = 19'h5A5A5;
    tick();
    mem_ack = 1'b0; exp_if_rdata = 19'h5A5A5;
    chk("fetch_valid", {if_valid, dm_valid, mem_req}, 3'b100);
    chk("fetch_rdata", if_rdata, exp_if_rdata);
    tick();
    chk("fetch_valid_pulse", if_valid, 1'b0);

    // Data write: captured address/data must hold while inputs wander.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 20'h00003; dm_wdata = 19'h7FFFF;
    tick();
    chk("wr_gnt", {dm_gnt, if_gnt, mem_req, mem_we}, 4'b1011);
    chk("wr_bus", {mem_addr, mem_wdata}, {20'h00003, 19'h7FFFF});
    dm_req = 1'b0; dm_addr = 20'h0ABCD; dm_wdata = 19'h00000; dm_we = 1'b0; last_dm = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wr_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 20'h00003, 19'h7FFFF});
    end
    mem_ack = 1'b1; mem_rdata = 19'h12345;
    tick();
    mem_ack = 1'b0;
    chk("wr_valid", {dm_valid, if_valid, mem_req}, 3'b100);
    chk("wr_rdata_kept", dm_rdata, exp_dm_rdata);

    // Acknowledge while idle must be ignored.
    tick();
    mem_ack = 1'b1; mem_rdata = 19'h11111;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack", {if_valid, dm_valid, mem_req}, 3'b000);
    chk("idle_ack_rdata", {if_rdata, dm_rdata}, {exp_if_rdata, exp_dm_rdata});

    // Request withdrawn before the sampling edge gets nothing.
    if_req = 1'b1;
    #2 if_req = 1'b0;
    tick();
    chk("req_withdrawn", {if_gnt, dm_gnt, mem_req}, 3'b000);

    // Both requesters held after reset: dm, fetch, dm, fetch with an idle cycle between.
    do_reset();
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_addr = 20'h00100; dm_addr = 20'h00200;
    for (int k = 0; k < 4; k++) begin
      win_dm = (k % 2 == 0);
      tick();
      chk("rr_gnt", {dm_gnt, if_gnt, mem_req}, {win_dm, !win_dm, 1'b1});
      rd = DW'($urandom);
      mem_ack = 1'b1; mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
      chk("rr_idle_gap", {dm_valid, if_valid, dm_gnt, if_gnt, mem_req}, {win_dm, !win_dm, 3'b000});
      if (win_dm) exp_dm_rdata = rd; else exp_if_rdata = rd;
      chk("rr_rdata", {if_rdata, dm_rdata}, {exp_if_rdata, exp_dm_rdata});
    end
    if_req = 1'b0; dm_req = 1'b0; last_dm = 1'b0;
    tick();

    // Reset one cycle after dm_gnt aborts the access without a valid pulse.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 20'h00044;
    tick();
    chk("rst_mid_gnt", {dm_gnt, mem_req}, 2'b11);
    dm_req = 1'b0;
    tick();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 19'h33333;
    #1;
    chk("rst_mid_async", {mem_req, dm_gnt, dm_valid}, 3'b000);
    tick();
    tick();
    mem_ack = 1'b0; reset = 1'b0;
    last_dm = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0;
    chk("rst_mid_rdata", {if_rdata, dm_rdata}, 0);
    tick();
    chk("rst_mid_no_valid", {dm_valid, if_valid, mem_req}, 3'b000);
    if_req = 1'b1; dm_req = 1'b1;
    tick();
    chk("rst_mid_rearb", {dm_gnt, if_gnt}, 2'b10);
    if_req = 1'b0; dm_req = 1'b0; last_dm = 1'b1;
    mem_ack = 1'b1; mem_rdata = 19'h0F0F0;
    tick();
    mem_ack = 1'b0; exp_dm_rdata = 19'h0F0F0;
    chk("rst_mid_done", {dm_valid, dm_rdata}, {1'b1, exp_dm_rdata});

`ifdef ARB_TIMEOUT_EN
    // Watchdog of 4: four busy cycles, then abort with valid + timeout_err.
    if_req = 1'b1; if_addr = 20'h00ABC;
    tick();
    chk("to_gnt", {if_gnt, mem_req}, 2'b11);
    if_req = 1'b0; last_dm = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("to_busy", {if_valid, timeout_err, mem_req}, 3'b001);
    end
    tick();
    chk("to_abort", {if_valid, timeout_err, mem_req}, 3'b110);
    chk("to_rdata_kept", if_rdata, exp_if_rdata);
    tick();
    chk("to_pulse", {if_valid, timeout_err}, 2'b00);
    // Ack in the expiry cycle completes normally.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 20'h00555;
    tick();
    dm_req = 1'b0; last_dm = 1'b1;
    tick();
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 19'h2468A;
    tick();
    mem_ack = 1'b0; exp_dm_rdata = 19'h2468A;
    chk("to_ack_tie", {dm_valid, timeout_err, mem_req}, 3'b100);
    chk("to_ack_tie_rdata", dm_rdata, exp_dm_rdata);
`else
    // No watchdog: a missing ack leaves the access pending indefinitely.
    if_req = 1'b1; if_addr = 20'h00ABC;
    tick();
    chk("noto_gnt", {if_gnt, mem_req}, 2'b11);
    if_req = 1'b0; last_dm = 1'b0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!mem_req || timeout_err || if_valid) bad++;
    end
    chk("noto_wait", bad, 0);
    mem_ack = 1'b1; mem_rdata = 19'h13579;
    tick();
    mem_ack = 1'b0; exp_if_rdata = 19'h13579;
    chk("noto_done", {if_valid, timeout_err, if_rdata}, {2'b10, exp_if_rdata});
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
      a_if = AW'($urandom); a_dm = AW'($urandom); wd = DW'($urandom);
      exp_we = 1'($urandom_range(0, 1));
      if_req = ir; dm_req = dr; if_addr = a_if; dm_addr = a_dm; dm_we = exp_we; dm_wdata = wd;
      tick();
      if (!ir && !dr) begin
        chk("rnd_idle", {if_gnt, dm_gnt, mem_req}, 3'b000);
        continue;
      end
      win_dm   = (ir && dr) ? !last_dm : dr;
      last_dm  = win_dm;
      exp_we   = win_dm && exp_we;
      exp_addr = win_dm ? a_dm : a_if;
      chk("rnd_gnt", {if_gnt, dm_gnt, mem_req}, {!win_dm, win_dm, 1'b1});
      chk("rnd_bus", {mem_we, mem_addr}, {exp_we, exp_addr});
      if (exp_we) chk("rnd_wdata", mem_wdata, wd);
      if_req = 1'b0; dm_req = 1'b0; if_addr = AW'($urandom); dm_addr = AW'($urandom);
      held = {1'b1, exp_we, exp_addr};
      for (int d = $urandom_range(0, 2); d > 0; d--) begin
        tick();
        chk("rnd_hold", {mem_req, mem_we, mem_addr}, held);
      end
      rd = DW'($urandom);
      mem_ack = 1'b1; mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
      chk("rnd_valid", {if_valid, dm_valid, timeout_err, mem_req}, {!win_dm, win_dm, 2'b00});
      if (!exp_we) begin
        if (win_dm) exp_dm_rdata = rd; else exp_if_rdata = rd;
      end
      chk("rnd_rdata", {if_rdata, dm_rdata}, {exp_if_rdata, exp_dm_rdata});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
